// File: rtl/sum_accumulator_if.sv
// Sample/result handshake bundle for sum_accumulator: sample stream in, block totals out.
// No latency of its own; flow control is valid/ready on both sides, and clear is a one-cycle flush request.
// Ready is driven by the slave on the input side and by the master on the output side.
interface sum_accumulator_if #(
    parameter int SAMPLE_W = 10,
    parameter int COUNT    = 4,
    parameter int ACC_W    = SAMPLE_W + $clog2(COUNT)
);
    logic                     in_valid;
    logic                     in_ready;
    logic [SAMPLE_W-1:0]      in_sum;
    logic                     clear;
    logic                     out_valid;
    logic                     out_ready;
    logic [ACC_W-1:0]         out_total;
    logic [SAMPLE_W-1:0]      out_avg;
    logic [$clog2(COUNT):0]   sample_cnt;

    modport master (
        output in_valid, in_sum, clear, out_ready,
        input  in_ready, out_valid, out_total, out_avg, sample_cnt
    );

    modport slave (
        input  in_valid, in_sum, clear, out_ready,
        output in_ready, out_valid, out_total, out_avg, sample_cnt
    );
endinterface

// File: rtl/sum_accumulator.sv
// Accumulates COUNT unsigned samples into a block total and average, then holds the result until it is taken.
// Result appears 1 cycle after the last accepted sample and stays stable until out_ready.
// While holding, in_ready is low, so no further samples are accepted; in_ready is a pure function of state.
module sum_accumulator #(
    parameter int SAMPLE_W = 10,
    parameter int COUNT    = 4,
    parameter int ACC_W    = SAMPLE_W + $clog2(COUNT)
) (
    input  logic             clk,
    input  logic             reset,
    sum_accumulator_if.slave bus
);
    localparam int LOG2  = $clog2(COUNT);
    localparam int CNT_W = LOG2 + 1;

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t              state;
    logic [ACC_W-1:0]    acc;
    logic [CNT_W-1:0]    cnt;
    logic [ACC_W-1:0]    total_q;
    logic [SAMPLE_W-1:0] avg_q;
    logic                in_ready_q;
    logic                out_valid_q;

    logic [ACC_W-1:0]    acc_next;
    logic [CNT_W-1:0]    cnt_next;
    logic [ACC_W-1:0]    avg_wide;

    always_comb begin
        acc_next = acc + ACC_W'(bus.in_sum);
        cnt_next = cnt + CNT_W'(1);
        avg_wide = acc_next >> LOG2;
    end

    // Priority: reset, then clear, then result handoff, then sample intake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ACCUM;
            acc         <= '0;
            cnt         <= '0;
            total_q     <= '0;
            avg_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (bus.clear) begin
            state       <= ACCUM;
            acc         <= '0;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (state == HOLD) begin
            if (bus.out_ready) begin
                state       <= ACCUM;
                acc         <= '0;
                cnt         <= '0;
                in_ready_q  <= 1'b1;
                out_valid_q <= 1'b0;
            end
        end else if (bus.in_valid) begin
            acc <= acc_next;
            cnt <= cnt_next;
            if (cnt_next == CNT_W'(COUNT)) begin
                state       <= HOLD;
                total_q     <= acc_next;
                avg_q       <= SAMPLE_W'(avg_wide);
                in_ready_q  <= 1'b0;
                out_valid_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_total  = total_q;
    assign bus.out_avg    = avg_q;
    assign bus.sample_cnt = cnt;
endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: blocks of hand-computed samples, scoreboard-checked on each result handoff.
module tb_sum_accumulator;
    localparam int SAMPLE_W = 10;
    localparam int COUNT    = 4;
    localparam int ACC_W    = 12;

    typedef struct {
        int total;
        int avg;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total_checks = 0;
    int   passed = 0;
    exp_t sb[$];

    sum_accumulator_if #(.SAMPLE_W(SAMPLE_W), .COUNT(COUNT), .ACC_W(ACC_W)) bus();

    sum_accumulator #(.SAMPLE_W(SAMPLE_W), .COUNT(COUNT), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total_checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: a handoff happens at the next rising edge whenever valid and ready are both high now.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", int'(bus.out_total), -1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_total", int'(bus.out_total), e.total);
                    chk("sb_avg", int'(bus.out_avg), e.avg);
                    chk("sb_cnt", int'(bus.sample_cnt), COUNT);
                end
            end
        end
    end

    task automatic send(input int v);
        int n;
        bus.in_valid = 1'b1;
        bus.in_sum   = SAMPLE_W'(v);
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        if (n == 50) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_sum   = SAMPLE_W'(777);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_block(input int total);
        exp_t e;
        e.total = total;
        e.avg   = total / COUNT;
        sb.push_back(e);
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sum    = '0;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_total", int'(bus.out_total), 0);
        chk("rst_out_avg", int'(bus.out_avg), 0);
        chk("rst_cnt", int'(bus.sample_cnt), 0);

        // Basic block, with a check of the one-cycle result latency.
        expect_block(576);
        send(259); send(42); send(176);
        chk("mid_cnt", int'(bus.sample_cnt), 3);
        send(99);
        chk("basic_out_valid", int'(bus.out_valid), 1);
        chk("basic_total", int'(bus.out_total), 576);
        chk("basic_avg", int'(bus.out_avg), 144);
        chk("basic_in_ready", int'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        chk("basic_back_accum", int'(bus.in_ready), 1);
        chk("basic_cnt0", int'(bus.sample_cnt), 0);
        chk("accum_keeps_total", int'(bus.out_total), 576);

        // Full-scale samples must not wrap.
        expect_block(4092);
        repeat (4) send(1023);
        idle(2);

        // Gaps between samples.
        expect_block(100);
        send(10); idle(3); send(20); send(30); idle(1); send(40);
        idle(2);

        // Backpressure: result held while upstream keeps offering samples.
        bus.out_ready = 1'b0;
        expect_block(10);
        send(1); send(2); send(3); send(4);
        bus.in_valid = 1'b1;
        bus.in_sum   = SAMPLE_W'(500);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", int'(bus.in_ready), 0);
            chk("bp_total", int'(bus.out_total), 10);
            chk("bp_cnt", int'(bus.sample_cnt), 4);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("bp_release_cnt", int'(bus.sample_cnt), 0);
        chk("bp_release_ready", int'(bus.in_ready), 1);
        idle(1);

        // Clear mid-block drops the partial block and the sample presented with it.
        send(5); send(6);
        bus.clear    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sum   = SAMPLE_W'(7);
        @(posedge clk);
        #1;
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        chk("clear_cnt", int'(bus.sample_cnt), 0);
        chk("clear_in_ready", int'(bus.in_ready), 1);
        expect_block(4);
        repeat (4) send(1);
        idle(2);

        // Reset while holding a result discards it.
        bus.out_ready = 1'b0;
        send(259); send(42); send(176); send(99);
        chk("hold_before_rst", int'(bus.out_valid), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("hrst_out_valid", int'(bus.out_valid), 0);
        chk("hrst_total", int'(bus.out_total), 0);
        chk("hrst_avg", int'(bus.out_avg), 0);
        chk("hrst_cnt", int'(bus.sample_cnt), 0);
        chk("hrst_in_ready", int'(bus.in_ready), 1);
        bus.out_ready = 1'b1;
        idle(3);

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter SAMPLE_W, default 10, SHALL set the width of each incoming adder-tree sum sample.
REQ-002 Parameter COUNT, default 4, SHALL set the samples per block; legal values are powers of two, 2..256.
REQ-003 Parameter ACC_W, default SAMPLE_W+log2(COUNT) = 12, SHALL set the accumulator width.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port in_valid, input, 1: in_sum holds a valid sample.
REQ-007 Port in_ready, output, 1: block can accept a sample this cycle.
REQ-008 Port in_sum, input, SAMPLE_W: unsigned sample (sum3 of the adder tree).
REQ-009 Port clear, input, 1: synchronous flush of the partial block.
REQ-010 Port out_valid, output, 1: result block available.
REQ-011 Port out_ready, input, 1: downstream accepts the result.
REQ-012 Port out_total, output, ACC_W: unsigned sum of the COUNT samples.
REQ-013 Port out_avg, output, SAMPLE_W: out_total >> log2(COUNT), truncated.
REQ-014 Port sample_cnt, output, log2(COUNT)+1: samples accepted into the current block.

Function
REQ-015 Two states SHALL exist: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-016 Input transfer SHALL occur when in_valid && in_ready at a rising edge; the sample is then added to acc and sample_cnt increments.
REQ-017 A sample SHALL NOT be accepted when in_valid=0; acc and sample_cnt hold.
REQ-018 On the transfer that makes sample_cnt reach COUNT, the FSM SHALL enter HOLD next cycle with out_total = final acc and out_valid=1 (latency 1 cycle from last accepted sample).
REQ-019 In HOLD, out_total, out_avg and sample_cnt (=COUNT) SHALL remain stable until output transfer (out_valid && out_ready).
REQ-020 On output transfer the FSM SHALL return to ACCUM with acc=0 and sample_cnt=0 on the next cycle; no sample is accepted in that transfer cycle.
REQ-021 Arithmetic SHALL be unsigned and zero-extended; ACC_W guarantees no overflow (COUNT x (2^SAMPLE_W-1) fits).
REQ-022 out_total and out_avg SHALL show the last completed block while in ACCUM (0 if none since reset), registered outputs only.
REQ-023 clear=1 SHALL, next cycle, force ACCUM, acc=0, sample_cnt=0, out_valid=0, discarding any partial or held block; a sample presented with clear is dropped.
REQ-024 Priority SHALL be reset > clear > output transfer > input transfer.
REQ-025 in_ready SHALL depend only on state (no combinational path from out_ready or in_valid).

Reset
REQ-026 While reset=1 at a rising edge: state=ACCUM, acc=0, sample_cnt=0, out_total=0, out_avg=0, out_valid=0; in_ready=1 from the cycle after reset deasserts.
REQ-027 Reset asserted mid-block or in HOLD SHALL discard all data identically to power-up reset.

Verification
REQ-028 Basic block: samples 259, 42, 176, 99 on consecutive cycles, out_ready=1 -> one cycle after 99: out_valid=1, out_total=576, out_avg=144, sample_cnt=4; ACCUM next cycle.
REQ-029 Max values: four samples of 1023 -> out_total=4092, out_avg=1023, no wrap.
REQ-030 Backpressure: complete a block with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, outputs stable, no extra samples counted; out_ready=1 -> ACCUM with sample_cnt=0.
REQ-031 Gaps: samples 10, (in_valid=0 x3), 20, 30, (gap), 40 -> out_total=100, out_avg=25.
REQ-032 Clear mid-block: accept 5, 6, assert clear with in_sum=7 valid -> sample_cnt=0 next cycle; then 1,1,1,1 -> out_total=4.
REQ-033 Reset in HOLD: block 259/42/176/99 held with out_ready=0, pulse reset -> out_valid=0, out_total=0, sample_cnt=0, in_ready=1 after release.
